// File: rtl/memio_stage_if.sv
// rtl/memio_stage_if.sv - memio_stage bus bundle: execute request, data memory, byte streams, writeback
interface memio_stage_if #(
  parameter int ADDR_W = 17
);
  logic              mem_en;
  logic              is_load;
  logic              is_store;
  logic              is_in;
  logic              is_out;
  logic              is_float;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       f_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic              wb_en;
  logic              f_wb_en;
  logic [31:0]       wb_data;
  logic              busy;
  logic              done;

  modport master (
    input  mem_en, is_load, is_store, is_in, is_out, is_float, addr, wdata, f_wdata,
    input  mem_rdata, in_valid, in_data, out_ready,
    output mem_addr, mem_wdata, mem_we, mem_re, in_ready, out_valid, out_data,
    output wb_en, f_wb_en, wb_data, busy, done
  );

  modport slave (
    output mem_en, is_load, is_store, is_in, is_out, is_float, addr, wdata, f_wdata,
    output mem_rdata, in_valid, in_data, out_ready,
    input  mem_addr, mem_wdata, mem_we, mem_re, in_ready, out_valid, out_data,
    input  wb_en, f_wb_en, wb_data, busy, done
  );
endinterface

// File: rtl/memio_stage.sv
// rtl/memio_stage.sv - load/store/in/out back-end stage; MEMIO_WORD_IO_EN selects 4-byte in/out transfers
module memio_stage #(
  parameter int ADDR_W  = 17,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  memio_stage_if.master bus
);

  typedef enum logic [2:0] {IDLE, MEM_RD, IN_WAIT, OUT_WAIT, FINISH} state_t;

  localparam int CNT_W = $clog2(MEM_LAT + 2);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              f_sel, f_sel_n;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
  logic [31:0]       mem_wdata_q, mem_wdata_n;
  logic              mem_we_q, mem_we_n;
  logic              mem_re_q, mem_re_n;
  logic              in_ready_q, in_ready_n;
  logic              out_valid_q, out_valid_n;
  logic [7:0]        out_data_q, out_data_n;
  logic              wb_en_q, wb_en_n;
  logic              f_wb_en_q, f_wb_en_n;
  logic [31:0]       wb_data_q, wb_data_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
`ifdef MEMIO_WORD_IO_EN
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [23:0]       in_asm, in_asm_n;
  logic [23:0]       out_word, out_word_n;
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    f_sel_n     = f_sel;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    mem_we_n    = 1'b0;
    mem_re_n    = 1'b0;
    in_ready_n  = in_ready_q;
    out_valid_n = out_valid_q;
    out_data_n  = out_data_q;
    wb_en_n     = 1'b0;
    f_wb_en_n   = 1'b0;
    wb_data_n   = wb_data_q;
    busy_n      = busy_q;
    done_n      = 1'b0;
`ifdef MEMIO_WORD_IO_EN
    byte_cnt_n  = byte_cnt;
    in_asm_n    = in_asm;
    out_word_n  = out_word;
`endif
    case (state)
      IDLE: begin
        if (bus.mem_en) begin
          busy_n  = 1'b1;
          f_sel_n = bus.is_float;
          if (bus.is_load) begin
            mem_re_n   = 1'b1;
            mem_addr_n = bus.addr;
            cnt_n      = CNT_W'(MEM_LAT);
            state_n    = MEM_RD;
          end else if (bus.is_store) begin
            mem_we_n    = 1'b1;
            mem_addr_n  = bus.addr;
            mem_wdata_n = bus.is_float ? bus.f_wdata : bus.wdata;
            cnt_n       = CNT_W'(1);
            state_n     = FINISH;
          end else if (bus.is_in) begin
            in_ready_n = 1'b1;
            state_n    = IN_WAIT;
`ifdef MEMIO_WORD_IO_EN
            byte_cnt_n = 2'd0;
`endif
          end else if (bus.is_out) begin
            out_valid_n = 1'b1;
            out_data_n  = bus.wdata[7:0];
            state_n     = OUT_WAIT;
`ifdef MEMIO_WORD_IO_EN
            byte_cnt_n  = 2'd0;
            out_word_n  = bus.wdata[31:8];
`endif
          end else begin
            // No operation flagged: just release the stall on the next edge.
            cnt_n   = '0;
            state_n = FINISH;
          end
        end
      end
      MEM_RD: begin
        if (cnt == '0) begin
          wb_data_n = bus.mem_rdata;
          wb_en_n   = ~f_sel;
          f_wb_en_n = f_sel;
          done_n    = 1'b1;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      FINISH: begin
        if (cnt == '0) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      IN_WAIT: begin
        if (bus.in_valid && in_ready_q) begin
`ifdef MEMIO_WORD_IO_EN
          in_asm_n   = {bus.in_data, in_asm[23:8]};
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            in_ready_n = 1'b0;
            wb_data_n  = {bus.in_data, in_asm};
            wb_en_n    = ~f_sel;
            f_wb_en_n  = f_sel;
            done_n     = 1'b1;
            busy_n     = 1'b0;
            state_n    = IDLE;
          end
`else
          in_ready_n = 1'b0;
          wb_data_n  = {24'd0, bus.in_data};
          wb_en_n    = ~f_sel;
          f_wb_en_n  = f_sel;
          done_n     = 1'b1;
          busy_n     = 1'b0;
          state_n    = IDLE;
`endif
        end
      end
      OUT_WAIT: begin
        if (out_valid_q && bus.out_ready) begin
`ifdef MEMIO_WORD_IO_EN
          if (byte_cnt == 2'd3) begin
            out_valid_n = 1'b0;
            done_n      = 1'b1;
            busy_n      = 1'b0;
            state_n     = IDLE;
          end else begin
            byte_cnt_n = byte_cnt + 2'd1;
            out_data_n = out_word[7:0];
            out_word_n = {8'd0, out_word[23:8]};
          end
`else
          out_valid_n = 1'b0;
          done_n      = 1'b1;
          busy_n      = 1'b0;
          state_n     = IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      f_sel       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wb_en_q     <= 1'b0;
      f_wb_en_q   <= 1'b0;
      wb_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEMIO_WORD_IO_EN
      byte_cnt    <= '0;
      in_asm      <= '0;
      out_word    <= '0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      f_sel       <= f_sel_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      mem_we_q    <= mem_we_n;
      mem_re_q    <= mem_re_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
      out_data_q  <= out_data_n;
      wb_en_q     <= wb_en_n;
      f_wb_en_q   <= f_wb_en_n;
      wb_data_q   <= wb_data_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
`ifdef MEMIO_WORD_IO_EN
      byte_cnt    <= byte_cnt_n;
      in_asm      <= in_asm_n;
      out_word    <= out_word_n;
`endif
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.f_wb_en   = f_wb_en_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_memio_stage.sv
// tb/tb_memio_stage.sv - scoreboard bench for memio_stage (MEM_LAT=1 and MEM_LAT=4 instances)
module tb_memio_stage;

  localparam logic [3:0] OP_LD  = 4'b1000;
  localparam logic [3:0] OP_ST  = 4'b0100;
  localparam logic [3:0] OP_IN  = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b0001;

  typedef struct packed {
    logic [1:0]  kind;   // 0 none, 1 integer wb, 2 float wb
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  logic [31:0] mem [0:255];
  logic [31:0] pipe4 [0:3];

  memio_stage_if #(.ADDR_W(17)) b1 ();
  memio_stage_if #(.ADDR_W(17)) b4 ();

  memio_stage #(.ADDR_W(17), .MEM_LAT(1)) dut1 (.clk(clk), .rstn(rstn), .bus(b1));
  memio_stage #(.ADDR_W(17), .MEM_LAT(4)) dut4 (.clk(clk), .rstn(rstn), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency memory shared by both instances.
  always @(posedge clk) begin
    if (b1.mem_we) mem[b1.mem_addr[7:0]] <= b1.mem_wdata;
    if (b4.mem_we) mem[b4.mem_addr[7:0]] <= b4.mem_wdata;
    b1.mem_rdata <= b1.mem_re ? mem[b1.mem_addr[7:0]] : 32'hDEAD_BEEF;
    pipe4[0]     <= b4.mem_re ? mem[b4.mem_addr[7:0]] : 32'hDEAD_BEEF;
    pipe4[1]     <= pipe4[0];
    pipe4[2]     <= pipe4[1];
    pipe4[3]     <= pipe4[2];
  end
  assign b4.mem_rdata = pipe4[3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue1(input logic [3:0] op, input logic fl, input logic [16:0] a,
                        input logic [31:0] wd, input logic [31:0] fwd);
    b1.mem_en = 1'b1;
    {b1.is_load, b1.is_store, b1.is_in, b1.is_out} = op;
    b1.is_float = fl; b1.addr = a; b1.wdata = wd; b1.f_wdata = fwd;
    tick();
    b1.mem_en = 1'b0;
    {b1.is_load, b1.is_store, b1.is_in, b1.is_out} = 4'b0000;
  endtask

  task automatic issue4(input logic [3:0] op, input logic [16:0] a);
    b4.mem_en = 1'b1;
    {b4.is_load, b4.is_store, b4.is_in, b4.is_out} = op;
    b4.is_float = 1'b0; b4.addr = a;
    tick();
    b4.mem_en = 1'b0;
    {b4.is_load, b4.is_store, b4.is_in, b4.is_out} = 4'b0000;
  endtask

  // Scoreboards: every done/writeback pulse consumes one expectation.
  always @(negedge clk) begin
    if (rstn && (b1.done || b1.wb_en || b1.f_wb_en)) begin
      check_eq("sb1_pending", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check_eq("sb1_done", b1.done, 1);
        check_eq("sb1_busy", b1.busy, 0);
        check_eq("sb1_wb_en", b1.wb_en, e1.kind == 2'd1);
        check_eq("sb1_f_wb_en", b1.f_wb_en, e1.kind == 2'd2);
        if (e1.kind != 2'd0) check_eq("sb1_wb_data", b1.wb_data, e1.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && (b4.done || b4.wb_en || b4.f_wb_en)) begin
      check_eq("sb4_pending", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        check_eq("sb4_done", b4.done, 1);
        check_eq("sb4_wb_en", b4.wb_en, e4.kind == 2'd1);
        if (e4.kind != 2'd0) check_eq("sb4_wb_data", b4.wb_data, e4.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  in_bytes [0:3];
    logic [31:0] out_word;
    int n;
    in_bytes[0] = 8'h78; in_bytes[1] = 8'h56; in_bytes[2] = 8'h34; in_bytes[3] = 8'h12;
    out_word = 32'h4433_2241;

    rstn = 1'b0;
    b1.mem_en = 0; b1.is_load = 0; b1.is_store = 0; b1.is_in = 0; b1.is_out = 0;
    b1.is_float = 0; b1.addr = '0; b1.wdata = '0; b1.f_wdata = '0;
    b1.in_valid = 0; b1.in_data = '0; b1.out_ready = 0;
    b4.mem_en = 0; b4.is_load = 0; b4.is_store = 0; b4.is_in = 0; b4.is_out = 0;
    b4.is_float = 0; b4.addr = '0; b4.wdata = '0; b4.f_wdata = '0;
    b4.in_valid = 0; b4.in_data = '0; b4.out_ready = 0;
    repeat (3) tick();

    check_eq("rst_busy", b1.busy, 0);
    check_eq("rst_done", b1.done, 0);
    check_eq("rst_strobes", {b1.mem_we, b1.mem_re, b1.in_ready, b1.out_valid, b1.wb_en, b1.f_wb_en}, 0);
    check_eq("rst_mem_addr", b1.mem_addr, 0);
    check_eq("rst_mem_wdata", b1.mem_wdata, 0);
    check_eq("rst_wb_data", b1.wb_data, 0);
    check_eq("rst_out_data", b1.out_data, 0);
    rstn = 1'b1;
    tick();

    // Integer store, then integer load of the same word.
    q1.push_back('{2'd0, 32'h0});
    issue1(OP_ST, 1'b0, 17'h10, 32'h1234_5678, 32'h0);
    check_eq("st_we", b1.mem_we, 1);
    check_eq("st_addr", b1.mem_addr, 32'h10);
    check_eq("st_wdata", b1.mem_wdata, 32'h1234_5678);
    check_eq("st_busy", b1.busy, 1);
    tick();
    check_eq("st_we_off", b1.mem_we, 0);
    check_eq("st_done_e1", b1.done, 0);
    tick();
    check_eq("st_done_e2", b1.done, 1);

    q1.push_back('{2'd1, 32'h1234_5678});
    issue1(OP_LD, 1'b0, 17'h10, 32'h0, 32'h0);
    check_eq("ld_re", b1.mem_re, 1);
    check_eq("ld_addr", b1.mem_addr, 32'h10);
    tick();
    check_eq("ld_re_off", b1.mem_re, 0);
    check_eq("ld_done_e1", b1.done, 0);
    tick();
    check_eq("ld_done_e2", b1.done, 1);
    check_eq("ld_wb_en", b1.wb_en, 1);
    check_eq("ld_f_wb_en", b1.f_wb_en, 0);

    // Float store issued in the load's done cycle (back-to-back), then float load.
    q1.push_back('{2'd0, 32'h0});
    issue1(OP_ST, 1'b1, 17'h5, 32'hFFFF_FFFF, 32'h3F80_0000);
    check_eq("b2b_we", b1.mem_we, 1);
    check_eq("fst_wdata", b1.mem_wdata, 32'h3F80_0000);
    tick();
    tick();
    check_eq("fst_done", b1.done, 1);
    q1.push_back('{2'd2, 32'h3F80_0000});
    issue1(OP_LD, 1'b1, 17'h5, 32'h0, 32'h0);
    tick();
    tick();
    check_eq("fld_f_wb_en", b1.f_wb_en, 1);
    check_eq("fld_wb_en", b1.wb_en, 0);

    // Input with a long stall; a stray mem_en while busy must be ignored.
`ifdef MEMIO_WORD_IO_EN
    q1.push_back('{2'd1, 32'h1234_5678});
`else
    q1.push_back('{2'd1, 32'h0000_00A5});
`endif
    issue1(OP_IN, 1'b0, 17'h0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      check_eq("in_wait_busy", b1.busy, 1);
      check_eq("in_wait_ready", b1.in_ready, 1);
      if (i == 3) begin
        b1.mem_en = 1'b1; b1.is_store = 1'b1;
      end
      tick();
      if (i == 3) begin
        b1.mem_en = 1'b0; b1.is_store = 1'b0;
        check_eq("busy_ignore_we", b1.mem_we, 0);
      end
    end
`ifdef MEMIO_WORD_IO_EN
    for (int k = 0; k < 4; k++) begin
      b1.in_valid = 1'b1; b1.in_data = in_bytes[k];
      if (k > 0) begin
        check_eq("in_word_ready", b1.in_ready, 1);
        check_eq("in_word_done", b1.done, 0);
      end
      tick();
    end
    b1.in_valid = 1'b0;
    check_eq("in_word_data", b1.wb_data, 32'h1234_5678);
`else
    b1.in_valid = 1'b1; b1.in_data = 8'hA5;
    tick();
    b1.in_valid = 1'b0;
    check_eq("in_data", b1.wb_data, 32'h0000_00A5);
`endif
    check_eq("in_done", b1.done, 1);
    check_eq("in_ready_off", b1.in_ready, 0);
    repeat (3) tick();

    // Output held off by the sink for 5 cycles.
    q1.push_back('{2'd0, 32'h0});
    issue1(OP_OUT, 1'b0, 17'h0, out_word, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check_eq("out_hold_valid", b1.out_valid, 1);
      check_eq("out_hold_data", b1.out_data, 32'h41);
      tick();
    end
    b1.out_ready = 1'b1;
`ifdef MEMIO_WORD_IO_EN
    for (int k = 0; k < 4; k++) begin
      check_eq("out_word_valid", b1.out_valid, 1);
      check_eq("out_word_byte", b1.out_data, 32'((out_word >> (8 * k)) & 32'hFF));
      tick();
    end
`else
    check_eq("out_done_early", b1.done, 0);
    tick();
`endif
    b1.out_ready = 1'b0;
    check_eq("out_done", b1.done, 1);
    check_eq("out_valid_off", b1.out_valid, 0);
    check_eq("out_no_wb", b1.wb_en, 0);

    // No operation flag: done on the next cycle.
    q1.push_back('{2'd0, 32'h0});
    issue1(4'b0000, 1'b0, 17'h0, 32'h0, 32'h0);
    check_eq("nop_done_e0", b1.done, 0);
    tick();
    check_eq("nop_done_e1", b1.done, 1);
    repeat (2) tick();

    // MEM_LAT=4: abort a load with reset, then run one to completion.
    issue4(OP_LD, 17'h10);
    check_eq("l4_re", b4.mem_re, 1);
    tick();
    check_eq("l4_re_off", b4.mem_re, 0);
    tick();
    rstn = 1'b0;
    tick();
    check_eq("l4_rst_busy", b4.busy, 0);
    check_eq("l4_rst_done", {b4.done, b4.wb_en}, 0);
    rstn = 1'b1;
    repeat (6) tick();
    check_eq("l4_no_stray_done", b4.done, 0);
    q4.push_back('{2'd1, 32'h1234_5678});
    issue4(OP_LD, 17'h10);
    n = 0;
    while (!b4.done && n < 20) begin
      tick();
      n++;
    end
    check_eq("l4_latency", n, 5);
    repeat (4) tick();

    check_eq("sb1_drained", q1.size(), 0);
    check_eq("sb4_drained", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memio_stage.md
Name: memio_stage

Overview:
- Back-end stage that takes over from the execute stage for instructions the execute stage does not write back itself: loads, stores, in and out.
- Drives a fixed-latency data memory and byte-stream input/output handshakes.
- Produces the final integer/float register writeback pulse and a done pulse that releases the core's stall.

Parameters:
ADDR_W, 17, data memory word-address width
MEM_LAT, 1, data memory read latency in cycles (>=1); mem_rdata valid MEM_LAT cycles after the edge that samples mem_re

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
mem_en  in  1  one-cycle start pulse from execute (execute_en with mem_access/in_en/out_en)
is_load  in  1  op is load
is_store  in  1  op is store
is_in  in  1  op is input
is_out  in  1  op is output
is_float  in  1  load/in targets float regfile; store sources f_wdata
addr  in  ADDR_W  memory word address (execute dout)
wdata  in  32  integer store/out data
f_wdata  in  32  float store data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_rdata  in  32  memory read data
in_valid  in  1  input byte available
in_data  in  8  input byte
in_ready  out  1  stage accepts input byte
out_valid  out  1  output byte presented
out_data  out  8  output byte
out_ready  in  1  sink accepts output byte
wb_en  out  1  integer regfile write pulse
f_wb_en  out  1  float regfile write pulse
wb_data  out  32  writeback value (shared by both regfiles)
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- All outputs registered. Reset: all strobes, wb_en, f_wb_en, done, busy, in_ready, out_valid = 0; mem_addr, mem_wdata, wb_data, out_data = 0; state IDLE.
- Reset mid-operation aborts immediately. No writeback or done is produced. Partial IO bytes are discarded.
- States: IDLE, MEM_RD, IN_WAIT, OUT_WAIT, FINISH.
- Op priority when several flags are set: load > store > in > out. If mem_en is high with no flag set, done pulses next cycle.
- mem_en while busy=1 is ignored; execute must not issue.
- Edge E0 is the edge that samples mem_en in IDLE. At E0, busy<=1 and operands are latched.
- Load:
  - mem_re=1 and mem_addr=addr during the cycle after E0 only.
  - A down-counter of MEM_LAT+1 cycles; mem_rdata is sampled at edge E0+MEM_LAT+1.
  - At that edge: wb_data<=mem_rdata; f_wb_en or wb_en (selected by is_float) <=1; done<=1; busy<=0.
  - Pulses last one cycle. Total latency MEM_LAT+1 edges.
- Store:
  - mem_we=1 for the cycle after E0, with mem_addr=addr and mem_wdata=(is_float ? f_wdata : wdata).
  - done pulse at E0+2 via FINISH. No writeback.
- In:
  - in_ready=1 from the cycle after E0.
  - A byte is accepted on each edge with in_valid&in_ready.
  - After the final byte: in_ready<=0, wb_data<=zero-extended byte, wb_en/f_wb_en and done pulse on that same edge.
  - The stage waits indefinitely for in_valid.
- Out:
  - out_valid=1 and out_data=wdata[7:0] from the cycle after E0.
  - Holds stable until an edge with out_valid&out_ready. Then out_valid<=0 and done<=1. No writeback.
- busy=1 from E0 until the edge that raises done; done and busy never overlap.
- Back-to-back: mem_en may arrive in the cycle where done=1; it is accepted at the next edge.

Optional Feature:
- Macro MEMIO_WORD_IO_EN.
- Defined: in and out each transfer 4 bytes, little-endian, with a 2-bit byte counter.
  - In assembles {b3,b2,b1,b0}; writeback occurs after the 4th handshake.
  - Out presents wdata[7:0], [15:8], [23:16], [31:24] in order; done follows the 4th handshake.
  - in_ready/out_valid stay high between bytes.
- Undefined: single byte per transfer as above; byte counter absent.

Test Plan:
- Load, MEM_LAT=1: memory[0x10]=0x12345678, mem_en with is_load, addr=0x10 -> mem_re pulse cycle 1, wb_en=1 and wb_data=0x12345678 at E0+2, done same cycle, f_wb_en=0.
- Float store then load: is_store, is_float, f_wdata=0x3F800000, addr=5 -> mem_we cycle 1, mem_wdata=0x3F800000, done at E0+2; then is_load, is_float at addr 5 -> f_wb_en=1, wb_data=0x3F800000.
- In with in_valid held low 10 cycles, then byte 0xA5 -> busy=1 throughout, in_ready=1, wb_en with wb_data=0x000000A5 on the accepting edge; with MEMIO_WORD_IO_EN, bytes 0x78,0x56,0x34,0x12 -> wb_data=0x12345678.
- Out with out_ready low 5 cycles, wdata=0x00000041 -> out_valid=1, out_data=0x41 stable for all 5 cycles, done one cycle after out_ready rises, no wb_en.
- Reset asserted during a load wait with MEM_LAT=4 -> next cycle busy=0, no wb_en/done; a subsequent load completes normally.
- Back-to-back: mem_en (store) issued in the done cycle of a previous load -> accepted, mem_we one cycle later; a mem_en while busy=1 is ignored, with no extra done.
